// File: rtl/debounce_edge_stage_if.sv
// Signal bundle between a raw input source and the debounce stage.
// The master side drives the raw level; the slave side (the debouncer)
// returns the cleaned level, edge pulses and the press counter.
interface debounce_edge_stage_if #(
  parameter int CNT_W = 8
);
  logic             raw_in;
  logic             level_out;
  logic             rise_pulse;
  logic             fall_pulse;
  logic [CNT_W-1:0] press_count;

  modport master (
    output raw_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  press_count
  );

  modport slave (
    input  raw_in,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output press_count
  );
endinterface

// File: rtl/debounce_edge_stage.sv
// Input conditioning for a bouncing switch: two-flop synchroniser, a
// four-state stability FSM producing a registered debounced level,
// one-cycle rise/fall pulses and a wrapping count of accepted presses.
module debounce_edge_stage #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  debounce_edge_stage_if.slave  bus
);

  localparam int             CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_FULL = CW'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    STABLE_LOW,
    CHECK_HIGH,
    STABLE_HIGH,
    CHECK_LOW
  } state_t;

  logic             s1;
  logic             s2;
  state_t           state;
  logic [CW-1:0]    cnt;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;
  logic [CNT_W-1:0] press_q;

  // Two-flop synchroniser bringing the asynchronous raw input into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      // NOTE: non-blocking so s2 takes last cycle's s1; a blocking
      // assignment here would collapse the two stages into one flop.
      s1 <= bus.raw_in;
      s2 <= s1;
    end
  end

  // Stability FSM: a level change is accepted only after STABLE_CYCLES
  // consecutive matching samples of s2; outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= STABLE_LOW;
      cnt     <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      press_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        STABLE_LOW: begin
          if (s2) begin
            state <= CHECK_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        CHECK_HIGH: begin
          if (!s2) begin
            state <= STABLE_LOW;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= STABLE_HIGH;
            cnt     <= CNT_FULL;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
            press_q <= press_q + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE_HIGH: begin
          if (!s2) begin
            state <= CHECK_LOW;
            cnt   <= CNT_ONE;
          end
        end
        CHECK_LOW: begin
          if (s2) begin
            state <= STABLE_HIGH;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= STABLE_LOW;
            cnt     <= CNT_FULL;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= STABLE_LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.level_out   = level_q;
  assign bus.rise_pulse  = rise_q;
  assign bus.fall_pulse  = fall_q;
  assign bus.press_count = press_q;

endmodule

// File: tb/tb_debounce_edge_stage.sv
// Scoreboard bench for debounce_edge_stage (STABLE_CYCLES=4, CNT_W=8).
// Stimulus pushes the expected pulse events; a negedge monitor pops and
// compares every time the DUT raises rise_pulse or fall_pulse.
module tb_debounce_edge_stage;

  localparam int CNT_W = 8;
  localparam int LAT   = 6;   // drive negedge -> pulse, in edges

  typedef enum int {EV_RISE = 1, EV_FALL = 2} ev_kind_t;
  typedef struct {
    ev_kind_t         kind;
    int               at;
    logic [CNT_W-1:0] count;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  debounce_edge_stage_if #(.CNT_W(CNT_W)) bus ();

  debounce_edge_stage #(.STABLE_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t              q[$];
  ev_t              mon_e;
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [CNT_W-1:0] exp_count;
  int               t_drv;
  bit               prev_pulse = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input ev_kind_t kind);
    if (kind == EV_RISE) exp_count++;
    q.push_back('{kind, t_drv + LAT, exp_count});
  endtask

  // Apply level v for n sampling edges; ev: 0 none, else expected event.
  task automatic drive(input logic v, input int n, input int ev);
    @(negedge clk);
    bus.raw_in = v;
    t_drv = cyc;
    if (ev == int'(EV_RISE)) push_ev(EV_RISE);
    if (ev == int'(EV_FALL)) push_ev(EV_FALL);
    repeat (n - 1) @(negedge clk);
  endtask

  // Monitor: compare each presented pulse against the scoreboard head.
  always @(negedge clk) begin
    if (bus.rise_pulse || bus.fall_pulse) begin
      check("pulse_exclusive", int'(bus.rise_pulse & bus.fall_pulse), 0);
      check("pulse_not_back_to_back", int'(prev_pulse), 0);
      check("pulse_expected", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("pulse_kind", bus.rise_pulse ? int'(EV_RISE) : int'(EV_FALL), int'(mon_e.kind));
        check("pulse_cycle", cyc, mon_e.at);
        check("pulse_level", int'(bus.level_out), int'(mon_e.kind == EV_RISE));
        check("pulse_press_count", int'(bus.press_count), int'(mon_e.count));
      end
    end
    prev_pulse = bus.rise_pulse | bus.fall_pulse;
  end

  initial begin
    int w;
    logic bounce [7];
    bounce = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset held 3 cycles with raw_in high.
    rst = 1'b1;
    bus.raw_in = 1'b1;
    exp_count = '0;
    repeat (3) @(negedge clk);
    check("reset_level", int'(bus.level_out), 0);
    check("reset_rise", int'(bus.rise_pulse), 0);
    check("reset_fall", int'(bus.fall_pulse), 0);
    check("reset_count", int'(bus.press_count), 0);
    rst = 1'b0;
    t_drv = cyc;
    push_ev(EV_RISE);
    repeat (5) @(negedge clk);
    check("level_before_latency", int'(bus.level_out), 0);
    repeat (3) @(negedge clk);
    check("level_after_reset_rise", int'(bus.level_out), 1);
    drive(1'b0, 12, int'(EV_FALL));

    // Clean press and release.
    drive(1'b1, 10, int'(EV_RISE));
    drive(1'b0, 12, int'(EV_FALL));

    // One-cycle bounce pattern: rejected.
    foreach (bounce[i]) drive(bounce[i], 1, 0);
    drive(1'b0, 8, 0);
    check("bounce1_level", int'(bus.level_out), 0);
    check("bounce1_count", int'(bus.press_count), int'(exp_count));

    // Three-cycle pulses: rejected.
    repeat (2) begin
      drive(1'b1, 3, 0);
      drive(1'b0, 6, 0);
    end
    check("bounce3_level", int'(bus.level_out), 0);
    check("bounce3_count", int'(bus.press_count), int'(exp_count));

    // Four-cycle pulse: accepted (boundary), then released.
    drive(1'b1, 4, int'(EV_RISE));
    drive(1'b0, 10, int'(EV_FALL));

    // Bounce then settle high.
    drive(1'b1, 1, 0);
    drive(1'b0, 1, 0);
    drive(1'b1, 1, 0);
    drive(1'b0, 1, 0);
    drive(1'b1, 10, int'(EV_RISE));
    drive(1'b0, 10, int'(EV_FALL));

    // 257 presses: press_count passes 255 -> 0 -> 1.
    repeat (257) begin
      drive(1'b1, 6, int'(EV_RISE));
      drive(1'b0, 6, int'(EV_FALL));
    end
    drive(1'b0, 4, 0);
    check("wrap_count", int'(bus.press_count), int'(exp_count));

    // Reset in the middle of a high check.
    drive(1'b1, 3, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midcheck_reset_count", int'(bus.press_count), 0);
    check("midcheck_reset_level", int'(bus.level_out), 0);
    rst = 1'b0;
    exp_count = '0;
    t_drv = cyc;
    push_ev(EV_RISE);
    repeat (10) @(negedge clk);
    check("midcheck_final_count", int'(bus.press_count), 1);

    // Drain the scoreboard with a bounded wait.
    w = 0;
    while (q.size() != 0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
